mac_array_ctrl: RTL
===================

# mac_array_ctrl

Sequencing controller for the weight-stationary MAC array: on a start pulse it walks every kernel position (kij), loading one weight tile, letting it settle, streaming activations, then draining partial sums. It generates the array's load/execute instruction bits and the L0 weight/activation read addresses. It also obeys back-pressure from the output FIFO. It sits between the testbench/top-level core and the MAC tile array.

## Interface
- row, 8, MAC array rows (weights loaded per tile, one row per cycle)
- col, 8, MAC array columns
- len_kij, 9, kernel positions per run
- len_nij, 36, activation vectors per kij
- addr_bw, 11, L0 address width
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- start  input  1  one-cycle run request, sampled only in IDLE
- ofifo_full  input  1  output FIFO cannot accept; stalls EXEC
- inst_w  output  1  array weight-load instruction
- inst_e  output  1  array execute instruction
- l0_rd  output  1  L0 read enable
- w_addr  output  addr_bw  weight address = kij*row + row_cnt
- a_addr  output  addr_bw  activation address = nij_cnt
- kij  output  clog2(len_kij)  current kernel position
- busy  output  1  run in progress (W_LOAD..NEXT)
- done  output  1  one-cycle pulse at run end

## Operation
- All outputs registered (Moore); reset value 0 for every output, counters, state=IDLE.
- IDLE: start=1 -> W_LOAD, kij=0. Other inputs ignored.
- W_LOAD: row cycles; inst_w=1, l0_rd=1, w_addr=kij*row+row_cnt, row_cnt 0..row-1 -> W_SETTLE.
- W_SETTLE: col cycles, all instruction bits 0 (weights propagate across columns) -> EXEC.
- EXEC: len_nij productive cycles; inst_e=1, l0_rd=1, a_addr=nij_cnt. ofifo_full=1 in a cycle: inst_e=0, l0_rd=0, nij_cnt holds, a_addr holds. Last productive cycle -> FLUSH.
- FLUSH: row+col-1 cycles, instruction bits 0, ofifo_full ignored -> NEXT.
- NEXT: 1 cycle; kij==len_kij-1 -> DONE, else kij+1, counters cleared -> W_LOAD.
- DONE: 1 cycle, done=1, busy=0 -> IDLE.
- start while busy or in DONE: ignored, no queuing.
- inst_w and inst_e never simultaneously high; l0_rd high iff one of them is high.
- Address arithmetic unsigned, truncated to addr_bw; parameters must satisfy len_kij*row <= 2^addr_bw (elaboration check).

## Timing
- start high in cycle 0 -> busy and inst_w high in cycle 1.
- No-stall cycles per kij: row + col + len_nij + (row+col-1) + 1; defaults 68.
- Default run, no stall: done high in cycle 1+68*9 = 613, busy low from cycle 613, IDLE in cycle 614.
- Each ofifo_full cycle in EXEC adds exactly one cycle; stall seen in cycle n affects outputs in cycle n+1 (registered).
- reset asserted mid-run: outputs 0 asynchronously, no done pulse; next start begins from kij=0.

## Structure
- Shared package mac_pkg: state enum (IDLE, W_LOAD, W_SETTLE, EXEC, FLUSH, NEXT, DONE), instruction bit positions (bit0=load, bit1=execute), default array-size constants.
- One natural sub-module: phase_cnt — loadable down-counter with terminal-count flag and hold enable, reused for each phase length.

## Test plan
- Reset: reset high for 3 cycles mid-EXEC -> all outputs 0 same cycle; start afterwards yields first inst_w one cycle later with w_addr=0.
- Full default run, no stall -> inst_w 72 cycles, inst_e 324 cycles total, done single pulse in cycle 613.
- Address check: kij=2 W_LOAD -> w_addr 16..23; EXEC a_addr 0..35 in order.
- Stall: ofifo_full high 5 cycles at nij=10 -> a_addr holds 10, inst_e low those cycles, done moves to cycle 618.
- start pulsed during busy and during DONE -> ignored, exactly one done per accepted start.
- Parameter sweep row=col=4, len_kij=1, len_nij=4 -> done in cycle 1+(4+4+4+7+1)=21.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and constants for the weight-stationary MAC array sequencer.
// State encoding, instruction bit positions and default array geometry.
package mac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W_LOAD,
    W_SETTLE,
    EXEC,
    FLUSH,
    NEXT,
    DONE
  } state_t;

  localparam int INST_LOAD = 0;
  localparam int INST_EXEC = 1;

  localparam logic [1:0] INST_NONE = 2'b00;
  localparam logic [1:0] INST_LD   = 2'(1 << INST_LOAD);
  localparam logic [1:0] INST_EX   = 2'(1 << INST_EXEC);

  localparam int ROW_DEF     = 8;
  localparam int COL_DEF     = 8;
  localparam int LEN_KIJ_DEF = 9;
  localparam int LEN_NIJ_DEF = 36;
  localparam int ADDR_BW_DEF = 11;

  // Width needed to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/phase_cnt.sv
// Loadable down-counter timing one sequencer phase; tc marks the phase's last cycle.
module phase_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         hold,
  output logic         tc
);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (!hold && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/mac_array_ctrl.sv
// Run sequencer for the MAC array: per kernel position load weights, settle,
// stream activations (stallable by the output FIFO), flush, then advance.
module mac_array_ctrl
  import mac_pkg::*;
#(
  parameter int row     = ROW_DEF,
  parameter int col     = COL_DEF,
  parameter int len_kij = LEN_KIJ_DEF,
  parameter int len_nij = LEN_NIJ_DEF,
  parameter int addr_bw = ADDR_BW_DEF,
  localparam int kij_w  = cnt_w(len_kij)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               ofifo_full,
  output logic               inst_w,
  output logic               inst_e,
  output logic               l0_rd,
  output logic [addr_bw-1:0] w_addr,
  output logic [addr_bw-1:0] a_addr,
  output logic [kij_w-1:0]   kij,
  output logic               busy,
  output logic               done
);

  localparam int FLUSH_LEN = row + col - 1;
  localparam int PH_MAX0   = (row > col) ? row : col;
  localparam int PH_MAX1   = (PH_MAX0 > len_nij) ? PH_MAX0 : len_nij;
  localparam int PH_MAX    = (PH_MAX1 > FLUSH_LEN) ? PH_MAX1 : FLUSH_LEN;
  localparam int PH_W      = cnt_w(PH_MAX);

  if (len_kij * row > (1 << addr_bw)) begin : g_bad_params
    $error("mac_array_ctrl: len_kij*row exceeds the L0 weight address space");
  end

  state_t            state;
  logic [1:0]        inst;
  logic              ph_load;
  logic [PH_W-1:0]   ph_val;
  logic              ph_hold;
  logic              ph_tc;
  logic [31:0]       next_base;
  logic              last_kij;
  logic              exec_now;

  assign inst_w   = inst[INST_LOAD];
  assign inst_e   = inst[INST_EXEC];
  assign exec_now = inst[INST_EXEC];
  assign last_kij = (kij == kij_w'(len_kij - 1));

  always_comb next_base = (32'(kij) + 32'd1) * 32'(row);

  // The counter is loaded with (phase length - 1) on the edge entering a
  // phase; in EXEC it only advances after productive (non-stalled) cycles.
  // NOTE: every signal driven here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    ph_load = 1'b0;
    ph_val  = '0;
    ph_hold = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          ph_load = 1'b1;
          ph_val  = PH_W'(row - 1);
        end
      end
      W_LOAD: begin
        if (ph_tc) begin
          ph_load = 1'b1;
          ph_val  = PH_W'(col - 1);
        end
      end
      W_SETTLE: begin
        if (ph_tc) begin
          ph_load = 1'b1;
          ph_val  = PH_W'(len_nij - 1);
        end
      end
      EXEC: begin
        if (exec_now && ph_tc) begin
          ph_load = 1'b1;
          ph_val  = PH_W'(FLUSH_LEN - 1);
        end else begin
          ph_hold = !exec_now;
        end
      end
      NEXT: begin
        if (!last_kij) begin
          ph_load = 1'b1;
          ph_val  = PH_W'(row - 1);
        end
      end
      default: ;
    endcase
  end

  phase_cnt #(.W(PH_W)) u_phase_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (ph_load),
    .load_val (ph_val),
    .hold     (ph_hold),
    .tc       (ph_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      inst   <= INST_NONE;
      l0_rd  <= 1'b0;
      w_addr <= '0;
      a_addr <= '0;
      kij    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= W_LOAD;
            kij    <= '0;
            busy   <= 1'b1;
            inst   <= INST_LD;
            l0_rd  <= 1'b1;
            w_addr <= '0;
          end
        end
        W_LOAD: begin
          if (ph_tc) begin
            state <= W_SETTLE;
            inst  <= INST_NONE;
            l0_rd <= 1'b0;
          end else begin
            w_addr <= w_addr + 1'b1;
          end
        end
        W_SETTLE: begin
          if (ph_tc) begin
            state  <= EXEC;
            inst   <= INST_EX;
            l0_rd  <= 1'b1;
            a_addr <= '0;
          end
        end
        EXEC: begin
          // A stalled cycle keeps showing the last issued address; the next
          // productive cycle issues the following one.
          if (exec_now && ph_tc) begin
            state <= FLUSH;
            inst  <= INST_NONE;
            l0_rd <= 1'b0;
          end else if (ofifo_full) begin
            inst  <= INST_NONE;
            l0_rd <= 1'b0;
          end else begin
            inst   <= INST_EX;
            l0_rd  <= 1'b1;
            a_addr <= a_addr + 1'b1;
          end
        end
        FLUSH: begin
          if (ph_tc) begin
            state <= NEXT;
          end
        end
        NEXT: begin
          if (last_kij) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state  <= W_LOAD;
            kij    <= kij + 1'b1;
            inst   <= INST_LD;
            l0_rd  <= 1'b1;
            w_addr <= next_base[addr_bw-1:0];
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
